// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron-layer input buffer.
// Contents:
//   nn_buf_state_t : buffer FSM state encoding (LOAD / COMPUTE / DRAIN)
//   NN_DATA_W      : default activation word width
package nn_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } nn_buf_state_t;

  localparam int NN_DATA_W = 8;

endpackage

// File: rtl/nn_relu_clamp.sv
// ReLU-style clamp for one signed activation word: negative words become 0,
// non-negative words pass unchanged. Purely combinational.
// Ports:
//   din  : signed input word  (DATA_W)
//   dout : clamped output word (DATA_W)
module nn_relu_clamp #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/nn_layer_input_buffer.sv
// Input/feedback buffer for the time-multiplexed neuron layer.
// Serially loads N_LANES host words, presents them in parallel to the neuron
// array, recirculates neuron results for N_LAYERS passes, then drains the
// final results serially (neuron N_LANES-1 first).
// Optional build macro: NN_FEEDBACK_RELU_EN -- intermediate-layer captures
// clamp negative words to 0; the final-layer capture stays raw.
// Ports:
//   clk, rstn     : clock (rising edge), synchronous active-low reset
//   flush         : synchronous abort, like reset but err is preserved
//   in_valid/in_ready/in_data        : host word input (accepted in LOAD)
//   lanes         : packed lane array, lane i at [i*DATA_W +: DATA_W]
//   layer_valid   : lanes hold a stable layer input (COMPUTE)
//   layer_idx     : current layer pass
//   neuron_valid/neuron_out          : one-cycle result pulse from neurons
//   out_valid/out_ready/out_data     : serial drain port (DRAIN)
//   err           : sticky, neuron_valid seen outside COMPUTE
module nn_layer_input_buffer
  import nn_pkg::*;
#(
  parameter int DATA_W   = NN_DATA_W,
  parameter int N_LANES  = 4,
  parameter int N_LAYERS = 3,
  localparam int LIDX_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int CNT_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [N_LANES*DATA_W-1:0]   lanes,
  output logic                        layer_valid,
  output logic [LIDX_W-1:0]           layer_idx,
  input  logic                        neuron_valid,
  input  logic [N_LANES*DATA_W-1:0]   neuron_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        err
);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(N_LANES - 1);
  localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(N_LAYERS - 1);

  nn_buf_state_t state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LIDX_W-1:0] layer_nxt;

  logic signed [DATA_W-1:0] lane     [N_LANES];
  logic signed [DATA_W-1:0] lane_nxt [N_LANES];
  logic signed [DATA_W-1:0] raw      [N_LANES];
  logic signed [DATA_W-1:0] capture  [N_LANES];

  logic load_acc, cmp_cap, drain_beat, last_layer;

  assign load_acc   = (state == ST_LOAD)    && in_valid;
  assign cmp_cap    = (state == ST_COMPUTE) && neuron_valid;
  assign drain_beat = (state == ST_DRAIN)   && out_ready;
  assign last_layer = (layer_idx == LAYER_LAST);

  // Status outputs decode straight from the state register, so there is no
  // combinational path from any input to them.
  assign in_ready    = (state == ST_LOAD);
  assign layer_valid = (state == ST_COMPUTE);
  assign out_valid   = (state == ST_DRAIN);
  assign out_data    = lane[N_LANES-1];

  for (genvar j = 0; j < N_LANES; j++) begin : g_raw
    assign raw[j] = neuron_out[j*DATA_W +: DATA_W];
  end

`ifdef NN_FEEDBACK_RELU_EN
  logic signed [DATA_W-1:0] clamped [N_LANES];
  for (genvar j = 0; j < N_LANES; j++) begin : g_clamp
    nn_relu_clamp #(.DATA_W(DATA_W)) u_clamp (
      .din  (raw[j]),
      .dout (clamped[j])
    );
    // Only feedback into another pass is clamped; the final results drain raw.
    assign capture[j] = last_layer ? raw[j] : clamped[j];
  end
`else
  for (genvar j = 0; j < N_LANES; j++) begin : g_capture
    assign capture[j] = raw[j];
  end
`endif

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    layer_nxt = layer_idx;
    unique case (state)
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            layer_nxt = '0;
            state_nxt = ST_COMPUTE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (neuron_valid) begin
          if (last_layer) state_nxt = ST_DRAIN;
          else            layer_nxt = layer_idx + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            layer_nxt = '0;
            state_nxt = ST_LOAD;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        cnt_nxt   = '0;
        layer_nxt = '0;
      end
    endcase
  end

  // Lane update: load and drain share the same upward shift, differing only
  // in what enters lane 0.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) lane_nxt[i] = lane[i];
    if (load_acc || drain_beat) begin
      lane_nxt[0] = load_acc ? $signed(in_data) : '0;
      for (int i = 1; i < N_LANES; i++) lane_nxt[i] = lane[i-1];
    end else if (cmp_cap) begin
      for (int i = 0; i < N_LANES; i++) lane_nxt[i] = capture[i];
    end
  end

  always_comb begin
    lanes = '0;
    for (int i = 0; i < N_LANES; i++) lanes[i*DATA_W +: DATA_W] = lane[i];
  end

  // Registered state, counters and lanes
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      layer_idx <= '0;
      for (int i = 0; i < N_LANES; i++) lane[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      layer_idx <= layer_nxt;
      for (int i = 0; i < N_LANES; i++) lane[i] <= lane_nxt[i];
    end
  end

  // err survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rstn)
      err <= 1'b0;
    else if (!flush && neuron_valid && (state != ST_COMPUTE))
      err <= 1'b1;
  end

endmodule

// File: tb/tb_nn_layer_input_buffer.sv
// Scoreboard bench for nn_layer_input_buffer (DATA_W=8, N_LANES=4, N_LAYERS=3).
module tb_nn_layer_input_buffer;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [7:0]  in_data;
  logic [31:0] lanes;
  logic        layer_valid;
  logic [1:0]  layer_idx;
  logic        neuron_valid;
  logic [31:0] neuron_out;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  nn_layer_input_buffer #(.DATA_W(8), .N_LANES(4), .N_LAYERS(3)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lanes(lanes), .layer_valid(layer_valid), .layer_idx(layer_idx),
    .neuron_valid(neuron_valid), .neuron_out(neuron_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every drain handshake pops one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && !flush && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL drain_unexpected actual=%h expected=none", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL drain_word actual=%h expected=%h", out_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) load_word(w[i*8 +: 8]);
  endtask

  task automatic pulse(input logic [31:0] d);
    neuron_out   = d;
    neuron_valid = 1'b1;
    tick();
    neuron_valid = 1'b0;
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check(name, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] bp_exp [4];
    logic [31:0] relu_exp;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    neuron_valid = 1'b0; neuron_out = '0; out_ready = 1'b0;
    tick(); tick();
    rstn = 1'b1;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_layer_valid", {31'd0, layer_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_lanes", lanes, 32'h0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_layer_idx", {30'd0, layer_idx}, 32'd0);

    // Load: first word ends in lane 3
    load_word(8'h11); load_word(8'h22); load_word(8'h33);
    check("load_not_yet", {31'd0, layer_valid}, 32'd0);
    load_word(8'h44);
    check("load_layer_valid", {31'd0, layer_valid}, 32'd1);
    check("load_lanes", lanes, 32'h11223344);
    check("load_in_ready_low", {31'd0, in_ready}, 32'd0);

    // Full pass, three layers then drain 04,03,02,01
    pulse(32'h04030201);
    check("pass_idx1", {30'd0, layer_idx}, 32'd1);
    check("pass_lanes", lanes, 32'h04030201);
    check("pass_layer_valid", {31'd0, layer_valid}, 32'd1);
    pulse(32'h04030201);
    check("pass_idx2", {30'd0, layer_idx}, 32'd2);
    exp_q.push_back(8'h04); exp_q.push_back(8'h03);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    pulse(32'h04030201);
    check("pass_drain", {31'd0, out_valid}, 32'd1);
    check("pass_idx_hold", {30'd0, layer_idx}, 32'd2);
    out_ready = 1'b1;
    wait_load("pass_back_to_load");
    out_ready = 1'b0;
    check("pass_queue_empty", exp_q.size(), 32'd0);
    check("pass_idx_zero", {30'd0, layer_idx}, 32'd0);

    // Backpressure: out_ready 1010... across 8 cycles
    load4(32'h01020304);
    pulse(32'h11111111);
    pulse(32'h22222222);
    bp_exp[0] = 8'hA4; bp_exp[1] = 8'hA3; bp_exp[2] = 8'hA2; bp_exp[3] = 8'hA1;
    for (int i = 0; i < 4; i++) exp_q.push_back(bp_exp[i]);
    pulse(32'hA4A3A2A1);
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 0);
      if (k % 2 == 1 && k < 6) check("bp_hold", {24'd0, out_data}, {24'd0, bp_exp[(k+1)/2]});
      tick();
    end
    out_ready = 1'b0;
    check("bp_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // Protocol error in LOAD: err sets, load progress unaffected
    load_word(8'h55); load_word(8'h66);
    pulse(32'hDEADBEEF);
    check("perr_err", {31'd0, err}, 32'd1);
    check("perr_lanes", {16'd0, lanes[15:0]}, 32'h00005566);
    load_word(8'h77);
    check("perr_still_load", {31'd0, in_ready}, 32'd1);
    load_word(8'h88);
    check("perr_layer_valid", {31'd0, layer_valid}, 32'd1);
    check("perr_lanes_full", lanes, 32'h55667788);
    check("perr_err_sticky", {31'd0, err}, 32'd1);

    // Flush at layer_idx=1: lanes clear, err preserved
    pulse(32'h0A0B0C0D);
    check("flush_pre_idx", {30'd0, layer_idx}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_lanes", lanes, 32'h0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_err", {31'd0, err}, 32'd1);
    check("flush_idx", {30'd0, layer_idx}, 32'd0);
    check("flush_layer_valid", {31'd0, layer_valid}, 32'd0);

    // Intermediate 8'h80 capture: clamped with the feature, raw without
`ifdef NN_FEEDBACK_RELU_EN
    relu_exp = 32'h00000000;
`else
    relu_exp = 32'h80808080;
`endif
    load4(32'h01020304);
    pulse(32'h80808080);
    check("relu_intermediate", lanes, relu_exp);
    pulse(32'h7F017F01);
    check("relu_positive", lanes, 32'h7F017F01);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h80);
    pulse(32'h80808080);
    check("relu_final_raw", lanes, 32'h80808080);
    out_ready = 1'b1;
    wait_load("relu_back_to_load");
    out_ready = 1'b0;
    check("relu_queue_empty", exp_q.size(), 32'd0);

    // Reset during DRAIN clears everything including err
    load4(32'h0F0E0D0C);
    pulse(32'h01010101);
    pulse(32'h02020202);
    pulse(32'h03030303);
    check("rstdrain_out_valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rstdrain_err", {31'd0, err}, 32'd0);
    check("rstdrain_out_valid_low", {31'd0, out_valid}, 32'd0);
    check("rstdrain_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstdrain_lanes", lanes, 32'h0);
    tick();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
